// File: rtl/alu_issue_ctrl.sv
// Operand-fetch / issue sequencer for the registered ALU: reads operands from a
// local register file, drives the ALU, captures result/flags and writes back.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ready for a request; operands fetched on accept
// S_ISSUE   | alu_ctrl/in_1/in_2 stable, ALU samples at end of cycle
// S_CAPTURE | alu_rslt/alu_checks valid; write-back and flags at edge
// S_RETIRE  | done (and err on rejected op) high for this cycle only
module alu_issue_ctrl #(
  parameter int RF_AW  = 4,
  parameter int MAX_OP = 23
) (
  input  logic             iss_clk,
  input  logic             iss_rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_op,
  input  logic [RF_AW-1:0] req_rs1,
  input  logic [RF_AW-1:0] req_rs2,
  input  logic [RF_AW-1:0] req_rd,
  output logic [5:0]       alu_ctrl,
  output logic [31:0]      in_1,
  output logic [31:0]      in_2,
  input  logic [31:0]      alu_rslt,
  input  logic [3:0]       alu_checks,
  output logic             done,
  output logic             err,
  output logic [31:0]      wb_data,
  output logic [3:0]       flags_q,
  input  logic [RF_AW-1:0] dbg_addr,
  output logic [31:0]      dbg_data
);

  localparam int NREG = 1 << RF_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RETIRE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      rf [NREG];
  logic [RF_AW-1:0] rd_q;
  logic             op_legal;

  assign op_legal = (req_op <= 6'(MAX_OP));
  // rf[0] is never written, so it reads as zero everywhere without a mux
  assign dbg_data = rf[dbg_addr];

  always_ff @(posedge iss_clk or negedge iss_rst_n) begin
    if (!iss_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = op_legal ? S_ISSUE : S_RETIRE;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RETIRE;
      S_RETIRE:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iss_clk or negedge iss_rst_n) begin
    if (!iss_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
      rd_q     <= '0;
      alu_ctrl <= '0;
      in_1     <= '0;
      in_2     <= '0;
      flags_q  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      wb_data  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            in_1 <= rf[req_rs1];
            in_2 <= rf[req_rs2];
            rd_q <= req_rd;
            if (op_legal) begin
              alu_ctrl <= req_op;
            end else begin
              // rejected op retires on the next cycle with no ALU activity
              done    <= 1'b1;
              err     <= 1'b1;
              wb_data <= '0;
            end
          end
        end
        S_CAPTURE: begin
          if (rd_q != '0) begin
            rf[rd_q] <= alu_rslt;
          end
          flags_q <= alu_checks;
          wb_data <= alu_rslt;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small registered-ALU model
// (0 ADD, 1 SUB, 15 load imm, 23 pass in_2; flags {V,Z,C,N}).
module tb_alu_issue_ctrl;

  logic        iss_clk = 1'b0;
  logic        iss_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [3:0]  req_rs1, req_rs2, req_rd;
  logic [5:0]  alu_ctrl;
  logic [31:0] in_1, in_2;
  logic [31:0] alu_rslt;
  logic [3:0]  alu_checks;
  logic        done, err;
  logic [31:0] wb_data;
  logic [3:0]  flags_q;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] imm;

  int checks   = 0;
  int failures = 0;
  int lat;

  always #5 iss_clk = ~iss_clk;

  alu_issue_ctrl #(.RF_AW(4), .MAX_OP(23)) dut (
    .iss_clk    (iss_clk),
    .iss_rst_n  (iss_rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .alu_ctrl   (alu_ctrl),
    .in_1       (in_1),
    .in_2       (in_2),
    .alu_rslt   (alu_rslt),
    .alu_checks (alu_checks),
    .done       (done),
    .err        (err),
    .wb_data    (wb_data),
    .flags_q    (flags_q),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  function automatic logic [35:0] alu_model(input logic [5:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] k);
    logic [32:0] s;
    logic        v;
    logic [31:0] r;
    s = '0;
    v = 1'b0;
    case (c)
      6'd0: begin
        s = {1'b0, a} + {1'b0, b};
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      6'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      6'd15:   s = {1'b0, k};
      6'd23:   s = {1'b0, b};
      default: s = '0;
    endcase
    r = s[31:0];
    return {v, (r == 32'd0), s[32], r[31], r};
  endfunction

  always @(posedge iss_clk) begin
    {alu_checks, alu_rslt} <= alu_model(alu_ctrl, in_1, in_2, imm);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dbg_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Called at a negedge in IDLE; returns at the negedge where done is seen.
  task automatic do_op(input logic [5:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, output int cyc);
    req_op    = op;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_rd    = rd;
    req_valid = 1'b1;
    @(negedge iss_clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 10) begin
      @(negedge iss_clk);
      cyc++;
    end
    if (!done) cyc = 99;
  endtask

  initial begin
    iss_rst_n = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_rd    = '0;
    dbg_addr  = '0;
    imm       = '0;

    // 1: reset state
    repeat (3) @(negedge iss_clk);
    iss_rst_n = 1'b1;
    for (int i = 0; i < 16; i++) dbg_chk("rst_rf", 4'(i), 32'd0);
    @(negedge iss_clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_flags", {28'd0, flags_q}, 32'd0);
    chk("rst_done", {30'd0, done, err}, 32'd0);
    chk("rst_ctrl", {26'd0, alu_ctrl}, 32'd0);
    chk("rst_in1", in_1, 32'd0);
    chk("rst_wb", wb_data, 32'd0);

    // 2: preload and overflowing ADD
    imm = 32'h7FFF_FFFF;
    do_op(6'd15, 4'd0, 4'd0, 4'd1, lat);
    chk("ld1_lat", lat, 32'd3);
    @(negedge iss_clk);
    imm = 32'h0000_0001;
    do_op(6'd15, 4'd0, 4'd0, 4'd2, lat);
    @(negedge iss_clk);
    dbg_chk("ld_r1", 4'd1, 32'h7FFF_FFFF);
    dbg_chk("ld_r2", 4'd2, 32'h0000_0001);
    do_op(6'd0, 4'd1, 4'd2, 4'd3, lat);
    chk("add_lat", lat, 32'd3);
    chk("add_err", {31'd0, err}, 32'd0);
    chk("add_wb", wb_data, 32'h8000_0000);
    chk("add_flags", {28'd0, flags_q}, 32'h9);
    chk("add_in1", in_1, 32'h7FFF_FFFF);
    chk("add_in2", in_2, 32'h0000_0001);
    dbg_chk("add_r3", 4'd3, 32'h8000_0000);
    @(negedge iss_clk);
    chk("add_done_once", {31'd0, done}, 32'd0);

    // 3: SUB to zero, write to r0 suppressed
    do_op(6'd1, 4'd3, 4'd3, 4'd4, lat);
    chk("sub_wb", wb_data, 32'd0);
    chk("sub_flags", {28'd0, flags_q}, 32'h6);
    dbg_chk("sub_r4", 4'd4, 32'd0);
    @(negedge iss_clk);
    do_op(6'd0, 4'd1, 4'd2, 4'd0, lat);
    chk("r0_wb", wb_data, 32'h8000_0000);
    dbg_chk("r0_read", 4'd0, 32'd0);
    @(negedge iss_clk);

    // 4: illegal op, MAX_OP boundary
    do_op(6'd30, 4'd1, 4'd2, 4'd5, lat);
    chk("ill_lat", lat, 32'd1);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_wb", wb_data, 32'd0);
    chk("ill_flags", {28'd0, flags_q}, 32'h9);
    chk("ill_ctrl", {26'd0, alu_ctrl}, 32'd0);
    dbg_chk("ill_r5", 4'd5, 32'd0);
    @(negedge iss_clk);
    chk("ill_after", {30'd0, done, err}, 32'd0);
    chk("ill_ready", {31'd0, req_ready}, 32'd1);
    do_op(6'd23, 4'd0, 4'd1, 4'd6, lat);
    chk("max_lat", lat, 32'd3);
    chk("max_err", {31'd0, err}, 32'd0);
    chk("max_ctrl", {26'd0, alu_ctrl}, 32'd23);
    dbg_chk("max_r6", 4'd6, 32'h7FFF_FFFF);
    @(negedge iss_clk);
    do_op(6'd24, 4'd1, 4'd2, 4'd6, lat);
    chk("over_lat", lat, 32'd1);
    chk("over_err", {31'd0, err}, 32'd1);
    chk("over_ctrl", {26'd0, alu_ctrl}, 32'd23);
    dbg_chk("over_r6", 4'd6, 32'h7FFF_FFFF);
    @(negedge iss_clk);

    // 5: back-to-back with req_valid held high
    req_op = 6'd0; req_rs1 = 4'd1; req_rs2 = 4'd2; req_rd = 4'd7;
    req_valid = 1'b1;
    chk("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
    @(negedge iss_clk);
    req_op = 6'd1; req_rs1 = 4'd7; req_rs2 = 4'd2; req_rd = 4'd8;
    chk("b2b_ready_issue", {31'd0, req_ready}, 32'd0);
    @(negedge iss_clk);
    chk("b2b_ready_capt", {31'd0, req_ready}, 32'd0);
    @(negedge iss_clk);
    chk("b2b_ready_ret", {31'd0, req_ready}, 32'd0);
    chk("b2b_a_done", {31'd0, done}, 32'd1);
    chk("b2b_a_wb", wb_data, 32'h8000_0000);
    @(negedge iss_clk);
    chk("b2b_ready_idle2", {31'd0, req_ready}, 32'd1);
    chk("b2b_idle_done", {31'd0, done}, 32'd0);
    @(negedge iss_clk);
    req_valid = 1'b0;
    chk("b2b_b_in1", in_1, 32'h8000_0000);
    chk("b2b_b_ctrl", {26'd0, alu_ctrl}, 32'd1);
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge iss_clk);
      lat++;
    end
    chk("b2b_b_lat", lat, 32'd3);
    chk("b2b_b_wb", wb_data, 32'h7FFF_FFFF);
    chk("b2b_b_flags", {28'd0, flags_q}, 32'hA);
    dbg_chk("b2b_r7", 4'd7, 32'h8000_0000);
    dbg_chk("b2b_r8", 4'd8, 32'h7FFF_FFFF);
    lat = 0;
    repeat (6) begin
      @(negedge iss_clk);
      if (done) lat++;
    end
    chk("b2b_no_extra", lat, 32'd0);

    // 6: reset during CAPTURE
    req_op = 6'd0; req_rs1 = 4'd1; req_rs2 = 4'd2; req_rd = 4'd9;
    req_valid = 1'b1;
    @(negedge iss_clk);
    req_valid = 1'b0;
    @(negedge iss_clk);
    iss_rst_n = 1'b0;
    #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_flags", {28'd0, flags_q}, 32'd0);
    chk("abort_wb", wb_data, 32'd0);
    dbg_chk("abort_r1", 4'd1, 32'd0);
    lat = 0;
    repeat (2) begin
      @(negedge iss_clk);
      if (done) lat++;
    end
    iss_rst_n = 1'b1;
    @(negedge iss_clk);
    if (done) lat++;
    chk("abort_no_done", lat, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    dbg_chk("abort_r9", 4'd9, 32'd0);
    imm = 32'd5;
    do_op(6'd15, 4'd0, 4'd0, 4'd10, lat);
    chk("post_lat", lat, 32'd3);
    chk("post_wb", wb_data, 32'd5);
    dbg_chk("post_r10", 4'd10, 32'd5);
    @(negedge iss_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
